// File: rtl/paralelo_serial_tx_pkg.sv
// Shared PHY constants and state encoding for the serial transmitter and its matching receiver.
package paralelo_serial_tx_pkg;
  localparam int         PHY_WIDTH      = 8;
  localparam logic [7:0] PHY_COMMA      = 8'hBC;
  localparam int         PHY_SYNC_WORDS = 4;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_t;
endpackage

// File: rtl/paralelo_serial_tx.sv
// Word-to-serial transmitter, MSB first, comma fill when idle; a word accepted on edge N shows its MSB from edge N.
// ready_out pulses once per word boundary in RUN; an unaccepted valid_in simply waits for the next pulse.
module paralelo_serial_tx
  import paralelo_serial_tx_pkg::*;
#(
  parameter int               WIDTH      = PHY_WIDTH,
  parameter logic [WIDTH-1:0] COMMA      = PHY_COMMA,
  parameter int               SYNC_WORDS = PHY_SYNC_WORDS
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             active,
  output logic             word_start
);

  localparam int CW = $clog2(WIDTH);
  localparam int SW = $clog2(SYNC_WORDS + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [SW-1:0] LAST_SYNC = SW'(SYNC_WORDS - 1);

  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic [SW-1:0]    sync_cnt;
  tx_state_t        state;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      shift_reg <= '0;
      bit_cnt   <= LAST_BIT;
      sync_cnt  <= '0;
      state     <= ST_SYNC;
      active    <= 1'b0;
    end else if (bit_cnt == LAST_BIT) begin
      bit_cnt <= '0;
      if (state == ST_SYNC) begin
        shift_reg <= COMMA;
        sync_cnt  <= sync_cnt + SW'(1);
        // The edge loading the last preamble comma also opens the data path.
        if (sync_cnt == LAST_SYNC) begin
          state  <= ST_RUN;
          active <= 1'b1;
        end
      end else begin
        shift_reg <= valid_in ? data_in : COMMA;
      end
    end else begin
      shift_reg <= shift_reg << 1;
      bit_cnt   <= bit_cnt + CW'(1);
    end
  end

  assign ready_out  = (state == ST_RUN) && (bit_cnt == LAST_BIT);
  assign data_out   = shift_reg[WIDTH-1];
  // The reset value of shift_reg is not a word, so no start marker until the first load.
  assign word_start = (bit_cnt == '0) && ((state != ST_SYNC) || (sync_cnt != '0));

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench: stimulus queues the word expected at each boundary, a monitor checks every serial bit.
module tb_paralelo_serial_tx;
  localparam logic [7:0] COMMA = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, data_out, active, word_start;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  int hs_cnt = 0;
  bit done = 1'b0;
  logic [7:0] exp_q[$];

  paralelo_serial_tx dut (
    .clk_32f   (clk_32f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .active    (active),
    .word_start(word_start)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected word at each word_start and checks its bits MSB first.
  initial begin
    logic [7:0] cur;
    int idx;
    idx = -1;
    cur = 8'h00;
    forever begin
      @(negedge clk_32f);
      if (!reset_L) begin
        idx = -1;
      end else if (!done) begin
        if (word_start) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow: word_start with no expected word (t=%0t)", $time);
            idx = -1;
          end else begin
            cur = exp_q.pop_front();
            idx = 7;
          end
        end
        if (idx >= 0) begin
          check($sformatf("serial_bit%0d_of_%0h", idx, cur), data_out, cur[idx]);
          idx--;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk_32f);
    if (ready_out === 1'b1) ready_cnt++;
    #2;
    if (ready_out === 1'b1 && valid_in === 1'b1) hs_cnt++;
  end

  // Waits for the ready pulse, offers (or withholds) a word, and queues what must go out.
  task automatic boundary(input logic v, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk_32f);
    while (ready_out !== 1'b1 && n < 20) begin
      @(negedge clk_32f);
      n++;
    end
    check("ready_wait", ready_out, 1);
    valid_in = v;
    data_in  = d;
    exp_q.push_back(v ? d : COMMA);
    @(posedge clk_32f);
    #1;
    valid_in = 1'b0;
    check("ready_low_after_boundary", ready_out, 0);
    check("word_start_after_boundary", word_start, 1);
  endtask

  // Preamble: edges 1,9,17,25 load commas, active from edge 25, first ready after edge 32.
  task automatic sync_check();
    repeat (4) exp_q.push_back(COMMA);
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk_32f);
      #1;
      check($sformatf("sync_active_e%0d", i), active, (i >= 25) ? 1 : 0);
      check($sformatf("sync_ready_e%0d", i), ready_out, (i == 32) ? 1 : 0);
      check($sformatf("sync_word_start_e%0d", i), word_start, ((i - 1) % 8 == 0) ? 1 : 0);
    end
  endtask

  initial begin
    int r0, h0;
    #12;
    check("rst_data_out", data_out, 0);
    check("rst_ready", ready_out, 0);
    check("rst_active", active, 0);
    check("rst_word_start", word_start, 0);
    @(negedge clk_32f);
    reset_L = 1'b1;
    sync_check();

    // Back-to-back FF, EE: no comma between, two ready pulses.
    r0 = ready_cnt;
    boundary(1'b1, 8'hFF);
    boundary(1'b1, 8'hEE);
    check("b2b_ready_pulses", ready_cnt - r0, 2);

    // FF then idle: commas follow and ready keeps pulsing.
    r0 = ready_cnt;
    boundary(1'b1, 8'hFF);
    boundary(1'b0, 8'h00);
    boundary(1'b0, 8'h00);
    check("idle_ready_pulses", ready_cnt - r0, 3);

    // valid raised 3 cycles before the boundary waits and is sent once.
    h0 = hs_cnt;
    repeat (5) @(posedge clk_32f);
    #1;
    valid_in = 1'b1;
    data_in  = 8'h5A;
    check("early_valid_no_ready", ready_out, 0);
    boundary(1'b1, 8'h5A);
    boundary(1'b0, 8'h00);
    check("early_valid_handshakes", hs_cnt - h0, 1);

    // Data equal to the comma is sent and counted as accepted.
    h0 = hs_cnt;
    boundary(1'b1, COMMA);
    check("comma_data_handshake", hs_cnt - h0, 1);
    check("comma_data_active", active, 1);

    // Reset at bit 3 of EE, then the full preamble again.
    boundary(1'b1, 8'hEE);
    repeat (4) @(posedge clk_32f);
    #2;
    reset_L = 1'b0;
    #1;
    check("midrst_data_out", data_out, 0);
    check("midrst_active", active, 0);
    check("midrst_ready", ready_out, 0);
    repeat (3) @(negedge clk_32f);
    exp_q.delete();
    reset_L = 1'b1;
    sync_check();
    h0 = hs_cnt;
    boundary(1'b1, 8'h3C);
    boundary(1'b0, 8'h00);
    check("post_reset_handshake", hs_cnt - h0, 1);

    repeat (3) @(negedge clk_32f);
    check("scoreboard_drained", exp_q.size(), 0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
